// File: rtl/video_sync_receiver.sv
// Sink-side VGA timing receiver: measures line/frame periods, qualifies lock over
// consecutive good frames and recovers lock-gated visible pixel coordinates.
module video_sync_receiver #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk_vga,
  input  logic        rst,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_n_in,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        pixel_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] h_total_meas,
  output logic [9:0]  v_total_meas,
  output logic [7:0]  err_cnt
);
  localparam int unsigned HW     = 11;
  localparam int unsigned VW     = 10;
  localparam int unsigned XW     = 10;
  localparam int unsigned YW     = 9;
  localparam int unsigned LINE_W = 10;
  localparam int unsigned GOOD_W = 4;
  localparam int unsigned ERR_W  = 8;

  localparam logic [HW-1:0]    H_SAT   = '1;
  localparam logic [VW-1:0]    V_SAT   = '1;
  localparam logic [XW-1:0]    X_SAT   = '1;
  localparam logic [ERR_W-1:0] ERR_SAT = '1;

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  logic hs_q, vs_q, de_q, hs_d, vs_d, de_d;
  logic hfall, vfall, derise, defall;
  logic [HW-1:0] h_cnt, h_per;
  logic [VW-1:0] v_cnt, v_per;
  logic hlost, vlost, line_err;
  logic h_err, v_err, h_sat, v_sat, frame_ok;
  logic [XW-1:0] x_cnt, x_nxt;
  logic [LINE_W-1:0] act_line, act_nxt;
  logic pv_nxt;
  state_t state, state_nxt;
  logic [GOOD_W-1:0] good, good_nxt;
  logic err_inc;

  // Sync inputs idle high and DE idle low so reset release never looks like an edge
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      de_q <= 1'b0;
      hs_d <= 1'b1;
      vs_d <= 1'b1;
      de_d <= 1'b0;
    end else begin
      hs_q <= hs_in;
      vs_q <= vs_in;
      de_q <= blank_n_in;
      hs_d <= hs_q;
      vs_d <= vs_q;
      de_d <= de_q;
    end
  end

  // Edge decode and period qualification
  always_comb begin
    hfall    = hs_d & ~hs_q;
    vfall    = vs_d & ~vs_q;
    derise   = ~de_d & de_q;
    defall   = de_d & ~de_q;
    h_per    = h_cnt + HW'(1);
    v_per    = v_cnt + VW'(1);
    h_err    = hfall & (h_per != HW'(H_TOTAL));
    v_err    = vfall & (v_per != VW'(V_TOTAL));
    h_sat    = ~hfall & (hlost | (h_cnt == H_SAT - HW'(1)));
    v_sat    = ~vfall & (vlost | (hfall & (v_cnt == V_SAT - VW'(1))));
    frame_ok = (v_per == VW'(V_TOTAL)) & ~line_err & ~h_err;
  end

  // Coordinate next values; pixel_valid follows the lock decision of this same update
  always_comb begin
    x_nxt = x_cnt;
    if (derise) begin
      x_nxt = '0;
    end else if (de_q && (x_cnt != X_SAT)) begin
      x_nxt = x_cnt + XW'(1);
    end
    act_nxt = act_line;
    if (vfall) begin
      act_nxt = '0;
    end else if (defall) begin
      act_nxt = act_line + LINE_W'(1);
    end
    pv_nxt = de_q & (state_nxt == LOCKED);
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      hlost        <= 1'b0;
      vlost        <= 1'b0;
      line_err     <= 1'b0;
      x_cnt        <= '0;
      act_line     <= '0;
      h_total_meas <= '0;
      v_total_meas <= '0;
    end else begin
      x_cnt    <= x_nxt;
      act_line <= act_nxt;
      if (hfall) begin
        h_cnt        <= '0;
        h_total_meas <= h_per;
      end else if (h_cnt != H_SAT) begin
        h_cnt <= h_per;
      end
      hlost <= hfall ? 1'b0 : (hlost | (h_cnt == H_SAT - HW'(1)));
      if (vfall) begin
        v_cnt        <= '0;
        v_total_meas <= v_per;
      end else if (hfall && (v_cnt != V_SAT)) begin
        v_cnt <= v_per;
      end
      vlost    <= vfall ? 1'b0 : (vlost | (hfall & (v_cnt == V_SAT - VW'(1))));
      line_err <= vfall ? 1'b0 : (line_err | h_err);
    end
  end

  // Lock FSM next-state
  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    err_inc   = 1'b0;
    case (state)
      SEARCH: begin
        if (vfall) begin
          state_nxt = CHECK;
          good_nxt  = '0;
        end
      end
      CHECK: begin
        if (h_sat | v_sat) begin
          state_nxt = SEARCH;
        end else if (vfall) begin
          if (frame_ok) begin
            good_nxt = good + GOOD_W'(1);
            if (good + GOOD_W'(1) == GOOD_W'(LOCK_FRAMES)) begin
              state_nxt = LOCKED;
            end
          end else begin
            good_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (h_err | v_err | h_sat | v_sat) begin
          state_nxt = SEARCH;
          err_inc   = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      state <= SEARCH;
      good  <= '0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_cnt     <= '0;
    end else begin
      x           <= pv_nxt ? x_nxt : '0;
      y           <= pv_nxt ? act_nxt[YW-1:0] : '0;
      pixel_valid <= pv_nxt;
      frame_start <= vfall;
      locked      <= (state_nxt == LOCKED);
      if (err_inc && (err_cnt != ERR_SAT)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_video_sync_receiver.sv
// Bench for video_sync_receiver: small-raster VGA stream with randomized phases and faults,
// every cycle compared against an event/timestamp reference model.
module tb_video_sync_receiver;
  localparam int HT     = 40;
  localparam int VT     = 20;
  localparam int LF     = 2;
  localparam int HSW    = 6;
  localparam int HDE0   = 14;
  localparam int HDEW   = 24;
  localparam int VSW    = 2;
  localparam int VDE0   = 3;
  localparam int VDEW   = 12;
  localparam int BUDGET = 6 * HT * VT;

  logic clk_vga = 1'b0;
  logic rst;
  logic hs_in, vs_in, blank_n_in;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        pixel_valid, frame_start, locked;
  logic [10:0] h_total_meas;
  logic [9:0]  v_total_meas;
  logic [7:0]  err_cnt;

  video_sync_receiver #(.H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(LF)) dut (
    .clk_vga(clk_vga), .rst(rst), .hs_in(hs_in), .vs_in(vs_in), .blank_n_in(blank_n_in),
    .x(x), .y(y), .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas), .err_cnt(err_cnt)
  );

  always #5 clk_vga = ~clk_vga;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stream generator: each line starts at HS fall; VS falls together with HS at line 0
  int gh, gv, glen, ghold;

  task automatic gen_sample(output logic [2:0] s);
    if (ghold > 0) begin
      s = 3'b110;
      ghold--;
    end else begin
      s[2] = (gh >= HSW);
      s[1] = (gv >= VSW);
      s[0] = (gv >= VDE0) && (gv < VDE0 + VDEW) && (gh >= HDE0) && (gh < HDE0 + HDEW);
      gh++;
      if (gh >= glen) begin
        gh   = 0;
        glen = HT;
        gv   = (gv + 1) % VT;
      end
    end
  endtask

  // Reference model: timestamps of the last events, line/row counts and lock bookkeeping
  int cyc, t_hf, t_dr, hf_lines, df_rows, mode, good, e_hm, e_vm, e_err;
  bit frame_bad;
  logic [2:0] p1, p2;

  task automatic model_reset();
    cyc = 0; t_hf = 0; t_dr = 0; hf_lines = 0; df_rows = 0;
    mode = 0; good = 0; frame_bad = 0; e_hm = 0; e_vm = 0; e_err = 0;
    p1 = 3'b110; p2 = 3'b110;
  endtask

  task automatic model_step(output logic [50:0] e);
    bit hf, vf, dr, df, de, herr, hsat, vsat, fok, lose, pv;
    int age, per, lines, vper, ex, ey;
    cyc++;
    hf = p2[2] & ~p1[2];
    vf = p2[1] & ~p1[1];
    dr = ~p2[0] & p1[0];
    df = p2[0] & ~p1[0];
    de = p1[0];
    age   = cyc - 1 - t_hf;
    if (age > 2047) age = 2047;
    per   = (age + 1) % 2048;
    lines = (hf_lines > 1023) ? 1023 : hf_lines;
    vper  = (lines + 1) % 1024;
    herr  = hf && (per != HT);
    hsat  = !hf && (cyc - t_hf >= 2047);
    vsat  = !vf && (hf_lines + (hf ? 1 : 0) >= 1023);
    fok   = (vper == VT) && !frame_bad && !herr;
    lose  = herr || (vf && (vper != VT)) || hsat || vsat;
    case (mode)
      0: if (vf) begin mode = 1; good = 0; end
      1: begin
        if (hsat || vsat) mode = 0;
        else if (vf) begin
          if (fok) begin
            if (good + 1 == LF) mode = 2;
            else good++;
          end else good = 0;
        end
      end
      default: if (lose) begin mode = 0; if (e_err < 255) e_err++; end
    endcase
    if (hf) begin e_hm = per; t_hf = cyc; end
    if (vf) begin
      e_vm = vper; hf_lines = 0; df_rows = 0; frame_bad = 0;
    end else begin
      if (hf) hf_lines++;
      if (df) df_rows++;
      if (herr) frame_bad = 1;
    end
    if (dr) t_dr = cyc;
    pv = de && (mode == 2);
    ex = pv ? ((cyc - t_dr > 1023) ? 1023 : cyc - t_dr) : 0;
    ey = pv ? (df_rows % 512) : 0;
    e  = {10'(ex), 9'(ey), pv, vf, (mode == 2), 11'(e_hm), 10'(e_vm), 8'(e_err)};
  endtask

  int n_fs, n_pv;
  logic [18:0] first_xy, last_xy;
  logic lk_prev;

  task automatic run_cycle();
    logic [2:0]  s;
    logic [50:0] e;
    gen_sample(s);
    {hs_in, vs_in, blank_n_in} = s;
    lk_prev = locked;
    @(posedge clk_vga);
    #1;
    model_step(e);
    check_eq("outs", 64'({x, y, pixel_valid, frame_start, locked, h_total_meas,
                          v_total_meas, err_cnt}), 64'(e));
    if (frame_start) n_fs++;
    if (pixel_valid) begin
      if (n_pv == 0) first_xy = {x, y};
      last_xy = {x, y};
      n_pv++;
    end
    p2 = p1;
    p1 = s;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic run_until_fs(input int target, input string tag);
    int k;
    k = 0;
    while ((n_fs < target) && (k < BUDGET)) begin
      run_cycle();
      k++;
    end
    check_eq(tag, 64'(n_fs), 64'(target));
  endtask

  task automatic run_to(input int tv, input int th);
    int k;
    k = 0;
    while (!((gv == tv) && (gh == th)) && (ghold == 0) && (k < BUDGET)) begin
      run_cycle();
      k++;
    end
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    #1;
    check_eq("rst_outs", 64'({x, y, pixel_valid, frame_start, locked, h_total_meas,
                              v_total_meas, err_cnt}), 64'd0);
    repeat (ncyc) @(posedge clk_vga);
    #1;
    check_eq("rst_hold", 64'({x, y, pixel_valid, locked, err_cnt}), 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d;
    rst = 1'b1; hs_in = 1'b1; vs_in = 1'b1; blank_n_in = 1'b0;
    gh = $urandom_range(0, HT - 1);
    gv = $urandom_range(VSW, VT - 1);
    glen = HT; ghold = 0;
    n_fs = 0; n_pv = 0; first_xy = '0; last_xy = '0; lk_prev = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_vga);
    #1;
    check_eq("por_outs", 64'({x, y, pixel_valid, frame_start, locked, h_total_meas,
                              v_total_meas, err_cnt}), 64'd0);
    rst = 1'b0;

    // Acquisition from reset at a random phase
    n_fs = 0;
    run_until_fs(3, "acq_vf");
    check_eq("lock_at_vf3", 64'(locked), 64'd1);
    check_eq("unlocked_before_vf3", 64'(lk_prev), 64'd0);
    check_eq("h_meas", 64'(h_total_meas), 64'(HT));
    check_eq("v_meas", 64'(v_total_meas), 64'(VT));
    check_eq("err_nominal", 64'(err_cnt), 64'd0);

    // One full locked frame: coordinates and pixel count
    n_fs = 0; n_pv = 0;
    run_cycles(HT * VT);
    check_eq("fs_per_frame", 64'(n_fs), 64'd1);
    check_eq("pv_per_frame", 64'(n_pv), 64'(HDEW * VDEW));
    check_eq("first_px", 64'(first_xy), 64'({10'd0, 9'd0}));
    check_eq("last_px", 64'(last_xy), 64'({10'(HDEW - 1), 9'(VDEW - 1)}));

    // Stretched line while locked
    run_cycles($urandom_range(0, HT * VT - 1));
    d = $urandom_range(1, 3);
    glen = HT + d;
    begin
      int k;
      k = 0;
      while (locked && (k < 2 * HT + 8)) begin run_cycle(); k++; end
    end
    check_eq("stretch_drop", 64'(locked), 64'd0);
    check_eq("stretch_meas", 64'(h_total_meas), 64'(HT + d));
    check_eq("stretch_err", 64'(err_cnt), 64'd1);
    n_fs = 0;
    run_until_fs(3, "relock_stretch_vf");
    check_eq("relock_stretch", 64'(locked), 64'd1);
    check_eq("relock_stretch_prev", 64'(lk_prev), 64'd0);

    // HS stuck high for 3000 clocks while locked
    run_to($urandom_range(VSW, VT - 1), $urandom_range(0, HT - 1));
    check_eq("locked_pre_hold", 64'(locked), 64'd1);
    ghold = 3000;
    run_cycles(3000);
    check_eq("hold_drop", 64'(locked), 64'd0);
    check_eq("hold_err_once", 64'(err_cnt), 64'd2);
    n_fs = 0;
    run_until_fs(3, "relock_hold_vf");
    check_eq("relock_hold", 64'(locked), 64'd1);

    // Reset pulsed mid-frame inside the visible area
    run_to($urandom_range(VDE0, VDE0 + VDEW - 1), $urandom_range(HDE0, HDE0 + HDEW - 1));
    check_eq("locked_pre_rst", 64'(locked), 64'd1);
    do_reset($urandom_range(1, 5));
    n_fs = 0;
    run_until_fs(3, "relock_rst_vf");
    check_eq("relock_rst", 64'(locked), 64'd1);
    check_eq("relock_rst_prev", 64'(lk_prev), 64'd0);
    check_eq("err_after_rst", 64'(err_cnt), 64'd0);

    // Coincident HS/VS fall at frame boundary: one pulse, correct frame period
    n_fs = 0; n_pv = 0;
    run_cycles(HT * VT);
    check_eq("fs_once", 64'(n_fs), 64'd1);
    check_eq("v_meas_coinc", 64'(v_total_meas), 64'(VT));
    check_eq("pv_frame2", 64'(n_pv), 64'(HDEW * VDEW));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_sync_receiver.md
# video_sync_receiver

Sink-side counterpart of the 640x480@60 timing generator: it samples HS, VS and BLANK_N from the video bus, measures line and frame periods, and recovers per-pixel x/y coordinates plus a lock indication. It sits downstream of any block that drives the VGA DAC control pins, for example a loopback checker, a capture path or a frame-grabber front end. All coordinate outputs are gated by lock, so consumers never see coordinates from a stream that has not been validated.

## Interface
- H_TOTAL, 800, expected pixel clocks per line
- V_TOTAL, 525, expected lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert lock (1..15)
- clk_vga  in  1  pixel clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- hs_in  in  1  horizontal sync, active-low pulse
- vs_in  in  1  vertical sync, active-low pulse
- blank_n_in  in  1  data-enable, high in the visible area
- x  out  10  visible column, 0..639
- y  out  9  visible row, 0..479
- pixel_valid  out  1  x/y are a valid visible pixel and the receiver is locked
- frame_start  out  1  one-cycle pulse on each detected VS falling edge
- locked  out  1  stream matches H_TOTAL/V_TOTAL
- h_total_meas  out  11  last measured line period, in clocks
- v_total_meas  out  10  last measured frame period, in lines
- err_cnt  out  8  saturating count of lock losses

## Operation
- Input stage: hs_in, vs_in and blank_n_in are registered into hs_q, vs_q and de_q, then delayed once more into hs_d, vs_d and de_d for edge detection.
  - The hs_q, vs_q, hs_d and vs_d registers reset to 1; de_q and de_d reset to 0. This prevents a false edge at reset release.
- Edges: hfall = hs_d & ~hs_q; vfall = vs_d & ~vs_q; derise = ~de_d & de_q; defall = de_d & ~de_q.
- h_cnt (11 bit):
  - Cleared on hfall, otherwise incremented.
  - Saturates at 2047 and sets the hlost flag.
  - On hfall, h_total_meas <= h_cnt+1.
- v_cnt (10 bit):
  - Cleared on vfall, otherwise incremented on hfall.
  - Saturates at 1023.
  - On vfall, v_total_meas <= v_cnt+1.
  - If vfall and hfall occur in the same cycle, the clear wins.
- line_err: sticky flag, set on any hfall with h_cnt+1 != H_TOTAL; cleared on vfall.
- frame_ok, evaluated at vfall: (v_cnt+1 == V_TOTAL) && !line_err && no hfall error in this cycle.
- x counter:
  - Cleared on derise.
  - Incremented while de_q is high and it is not a derise cycle.
  - Saturates at 1023.
- Row counter:
  - act_line is cleared on vfall and incremented on defall.
  - y = act_line[8:0] while de_q is high.
- Output gating: pixel_valid = de_q & locked. x and y are forced to 0 when pixel_valid is low.
- Lock FSM:
  - SEARCH: on vfall, go to CHECK and set good = 0.
  - CHECK:
    - On vfall with frame_ok, increment good; when good+1 == LOCK_FRAMES, go to LOCKED.
    - On vfall with !frame_ok, set good = 0 and stay in CHECK.
    - Saturation of h_cnt or v_cnt returns the FSM to SEARCH.
  - LOCKED:
    - Any of the following returns the FSM to SEARCH immediately and increments err_cnt by 1 (saturating at 255): an hfall with a wrong period, a vfall with a wrong period, or h_cnt or v_cnt saturation.
- locked = (state == LOCKED).

## Timing
- Every input is sampled at posedge N into the _q registers. Edges are decoded combinationally from the _q and _d registers, and counters, FSM and outputs update at posedge N+1.
- On the first visible pixel (first clock with blank_n_in high), x=0 and pixel_valid=1, two posedges after the input transition.
- frame_start is high exactly one cycle: the cycle after the posedge that registers vfall.
- Loss of lock takes effect on the same update as the offending hfall, vfall or saturation.
- On rst: all outputs are 0, the FSM is in SEARCH, and every counter is 0. This holds immediately, mid-frame included. Reacquiring lock needs one partial frame plus LOCK_FRAMES full frames.
- Only the period measurements constrain lock. Sync pulse width, porch lengths and DE placement are not checked.

## Test plan
- Nominal 800x525 stream from reset with LOCK_FRAMES=2 -> locked rises after the 3rd vfall; h_total_meas=800, v_total_meas=525, err_cnt=0.
- Locked frame -> the first DE pixel shows x=0, y=0; the last shows x=639, y=479; pixel_valid high for exactly 307200 cycles per frame.
- While locked, one line stretched to 801 clocks -> locked drops at the following hfall update; err_cnt=1, h_total_meas=801. Lock returns after the next vfall plus 2 good frames.
- HS held high for 3000 clocks while locked -> h_cnt saturates at 2047, locked drops, err_cnt increments exactly once.
- rst pulsed mid-frame while locked -> all outputs read 0 during reset; after release, lock is reacquired at the 3rd vfall.
- VS and HS falling on the same clock at the frame boundary -> v_cnt restarts at 0, v_total_meas=525, frame_start pulses exactly once.
